qpsk_demodulator: RTL

//   Receive-side counterpart of digital_modulator_mod. Takes one hard-decision

---
 rtl/qpsk_demodulator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/qpsk_demodulator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | qpsk_demodulator: hard-decision QPSK symbols -> sync-framed byte FIFO   |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
module qpsk_demodulator #(
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter int         PAYLOAD_LEN = 4,
  parameter int         DIFF_EN     = 0,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic       sym_i,
  input  logic       sym_q,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       locked,
  output logic       overflow
);

  localparam int             c_AW      = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]  c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]     c_LAST    = 8'(PAYLOAD_LEN - 1);
  localparam logic [0:0]     c_ST_HUNT = 1'b0;
  localparam logic [0:0]     c_ST_LOCK = 1'b1;

  logic [0:0]      r_state;
  logic [1:0]      r_p_prev;
  logic [5:0]      r_sr;
  logic [5:0]      r_acc;
  logic [2:0]      r_hunt_cnt;
  logic [1:0]      r_sym_cnt;
  logic [7:0]      r_byte_cnt;
  logic            r_first_pend;
  logic            r_overflow;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic [7:0]      r_mem       [FIFO_DEPTH];
  logic            r_mem_first [FIFO_DEPTH];

  logic [1:0] w_phase;
  logic [1:0] w_dibit;
  logic [7:0] w_sr_next;
  logic [2:0] w_hunt_next;
  logic [7:0] w_byte;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_wr_en;

  // Gray map: 00->0, 01->1, 11->2, 10->3 is {i, i^q}
  assign w_phase     = {sym_i, sym_i ^ sym_q};
  assign w_dibit     = (DIFF_EN != 0) ? (w_phase - r_p_prev) : w_phase;
  assign w_sr_next   = {r_sr, w_dibit};
  assign w_hunt_next = (r_hunt_cnt == 3'd4) ? 3'd4 : r_hunt_cnt + 3'd1;
  assign w_byte      = {r_acc, w_dibit};
  assign w_push      = sym_valid && (r_state == c_ST_LOCK) && (r_sym_cnt == 2'd3);
  assign w_pop       = out_valid && out_ready;
  assign w_full      = (r_count == c_DEPTH);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_wr_en     = w_push && (!w_full || w_pop);

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign out_first = out_valid ? r_mem_first[r_rd_ptr] : 1'b0;
  assign locked    = (r_state == c_ST_LOCK);
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_HUNT;
      r_p_prev     <= 2'd0;
      r_sr         <= 6'd0;
      r_acc        <= 6'd0;
      r_hunt_cnt   <= 3'd0;
      r_sym_cnt    <= 2'd0;
      r_byte_cnt   <= 8'd0;
      r_first_pend <= 1'b0;
    end else if (sym_valid) begin
      r_p_prev <= w_phase;
      case (r_state)
        c_ST_HUNT: begin
          r_sr       <= w_sr_next[5:0];
          r_hunt_cnt <= w_hunt_next;
          if (w_sr_next == SYNC_WORD && w_hunt_next == 3'd4) begin
            r_state      <= c_ST_LOCK;
            r_sym_cnt    <= 2'd0;
            r_byte_cnt   <= 8'd0;
            r_first_pend <= 1'b1;
          end
        end
        default: begin
          r_acc     <= w_byte[5:0];
          r_sym_cnt <= r_sym_cnt + 2'd1;
          if (r_sym_cnt == 2'd3) begin
            r_first_pend <= 1'b0;
            r_byte_cnt   <= r_byte_cnt + 8'd1;
            if (r_byte_cnt == c_LAST) begin
              r_state    <= c_ST_HUNT;
              r_hunt_cnt <= 3'd0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_wr_en)
        r_overflow <= 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never read while empty, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr]       <= w_byte;
      r_mem_first[r_wr_ptr] <= r_first_pend;
    end
  end

endmodule
`default_nettype wire
